// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// state encodings and the interrupt ID width.
package int_ctrl_pkg;

  localparam int ID_W = 5;

  localparam logic [3:0] OFF_ENABLE  = 4'h0;
  localparam logic [3:0] OFF_PENDING = 4'h4;
  localparam logic [3:0] OFF_CLAIM   = 4'h8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage

// File: rtl/int_ctrl_if.sv
// Register bus, interrupt sources and core trap handshake of int_ctrl,
// plus the FSM state for observation.
interface int_ctrl_if #(parameter int NUM_IRQ = 8) ();

  logic                       wr_en_i;
  logic [31:0]                wr_addr_i;
  logic [31:0]                wr_data_i;
  logic [31:0]                rd_addr_i;
  logic [31:0]                rd_data_o;
  logic [NUM_IRQ-1:0]         irq_i;
  // int_req_o is the valid and int_ack_i the one-cycle take: a request is
  // consumed at the edge where both are high; int_id_o stays stable while
  // int_req_o is high, and a request leaves only by ack or disable.
  logic                       int_req_o;
  logic [int_ctrl_pkg::ID_W-1:0] int_id_o;
  logic                       int_ack_i;
  logic [1:0]                 fsm_state;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, irq_i, int_ack_i,
    input  rd_data_o, int_req_o, int_id_o, fsm_state
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, irq_i, int_ack_i,
    output rd_data_o, int_req_o, int_id_o, fsm_state
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit (index 0 wins).
module irq_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  always_comb begin
    valid = |vec;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Level-interrupt controller with enable/pending registers, fixed priority
// selection and a claim/complete handshake toward the core.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input logic      clk,
  input logic      rst,
  int_ctrl_if.slave bus
);

  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] cur_mask;
  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               wr_enable, wr_claim;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_id;
  logic               unused_bits;

  assign wr_enable = bus.wr_en_i && (bus.wr_addr_i[3:0] == OFF_ENABLE);
  assign wr_claim  = bus.wr_en_i && (bus.wr_addr_i[3:0] == OFF_CLAIM);
  assign cur_mask  = {{(NUM_IRQ-1){1'b0}}, 1'b1} << cur_id_q;
  assign unused_bits = ^{bus.wr_addr_i[31:4], bus.rd_addr_i[31:4], bus.wr_data_i};

  // Only sources still enabled after this cycle's write may start a request,
  // so a same-cycle disable never leaves a request without a pending source.
  irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .vec   (pending_q & enable_d),
    .valid (cand_valid),
    .id    (cand_id)
  );

  always_comb begin
    enable_d     = wr_enable ? bus.wr_data_i[NUM_IRQ-1:0] : enable_q;
    pending_d    = (pending_q | (bus.irq_i & enable_q & ~in_service_q)) & enable_d;
    in_service_d = in_service_q;
    state_d      = state_q;
    cur_id_d     = cur_id_q;

    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          state_d  = ST_REQ;
          cur_id_d = cand_id;
        end
      end
      ST_REQ: begin
        if ((enable_d & cur_mask) == '0) begin
          state_d = ST_IDLE;
        end else if (bus.int_ack_i) begin
          state_d      = ST_ACTIVE;
          pending_d    = pending_d & ~cur_mask;
          in_service_d = in_service_q | cur_mask;
        end
      end
      ST_ACTIVE: begin
        if (wr_claim && (bus.wr_data_i[ID_W-1:0] == cur_id_q)) begin
          state_d      = ST_IDLE;
          in_service_d = in_service_q & ~cur_mask;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reads return the state as it stands after this edge's write.
    rd_data_d = '0;
    case (bus.rd_addr_i[3:0])
      OFF_ENABLE:  rd_data_d[NUM_IRQ-1:0] = enable_d;
      OFF_PENDING: rd_data_d[NUM_IRQ-1:0] = pending_d;
      OFF_CLAIM: begin
        rd_data_d[31]     = (state_d == ST_ACTIVE);
        rd_data_d[ID_W-1:0] = cur_id_d;
      end
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      state_q      <= ST_IDLE;
      cur_id_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.rd_data_o = rd_data_q;
  assign bus.int_req_o = (state_q == ST_REQ);
  assign bus.int_id_o  = (state_q == ST_REQ) ? cur_id_q : '0;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a behavioural model.
module tb_int_ctrl;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int_ctrl_if #(.NUM_IRQ(N)) bus ();

  int_ctrl #(.NUM_IRQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  bit [N-1:0]  m_en, m_pend, m_insvc, new_en, new_pend;
  bit          m_req, m_trap, m_live;
  int          m_cur, pick;
  logic [31:0] m_rd;
  logic [31:0] exp_q[$];

  task automatic model_step();
    if (rst) begin
      m_en = '0; m_pend = '0; m_insvc = '0;
      m_req = 0; m_trap = 0; m_cur = 0; m_rd = '0; m_live = 1;
    end else if (m_live) begin
      new_en = m_en;
      if (bus.wr_en_i && bus.wr_addr_i[3:0] == 4'h0) new_en = bus.wr_data_i[N-1:0];
      for (int i = 0; i < N; i++)
        new_pend[i] = (m_pend[i] | (bus.irq_i[i] & m_en[i] & ~m_insvc[i])) & new_en[i];
      if (m_req) begin
        if (!new_en[m_cur]) m_req = 0;
        else if (bus.int_ack_i) begin
          m_req = 0; m_trap = 1; new_pend[m_cur] = 0; m_insvc[m_cur] = 1;
        end
      end else if (m_trap) begin
        if (bus.wr_en_i && bus.wr_addr_i[3:0] == 4'h8 && int'(bus.wr_data_i[4:0]) == m_cur) begin
          m_trap = 0; m_insvc[m_cur] = 0;
        end
      end else begin
        pick = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && new_en[i]) pick = i;
        if (pick >= 0) begin m_req = 1; m_cur = pick; end
      end
      m_en = new_en;
      m_pend = new_pend;
      case (bus.rd_addr_i[3:0])
        4'h0:    m_rd = 32'(m_en);
        4'h4:    m_rd = 32'(m_pend);
        4'h8:    m_rd = {m_trap, 26'b0, 5'(m_cur)};
        default: m_rd = '0;
      endcase
    end
    if (m_live) exp_q.push_back(m_rd);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (m_live) begin
      check("int_req", 32'(bus.int_req_o), 32'(m_req));
      check("int_id", 32'(bus.int_id_o), m_req ? 32'(m_cur) : 32'd0);
      if (exp_q.size() > 0) check("rd_data", bus.rd_data_o, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = {28'h0, a}; bus.wr_data_i = d;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus.rd_addr_i = {28'h0, a};
    @(negedge clk);
    check(name, bus.rd_data_o, exp);
  endtask

  task automatic ack();
    bus.int_ack_i = 1'b1;
    @(negedge clk);
    bus.int_ack_i = 1'b0;
  endtask

  task automatic wait_req(input int limit, input string name);
    int n = 0;
    while (!bus.int_req_o && n < limit) begin @(negedge clk); n++; end
    check(name, 32'(bus.int_req_o), 32'd1);
  endtask

  task automatic cleanup();
    bus.irq_i = '0;
    if (m_trap) wr(4'h8, 32'(m_cur));
    wr(4'h0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] off;
    rst = 1'b1;
    bus.wr_en_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.rd_addr_i = '0; bus.irq_i = '0; bus.int_ack_i = 0;
    repeat (2) @(negedge clk);
    check("reset_req", 32'(bus.int_req_o), 32'd0);
    check("reset_id", 32'(bus.int_id_o), 32'd0);
    check("reset_rd", bus.rd_data_o, 32'd0);
    rst = 1'b0;

    // register map corners
    rd_chk(4'h8, 32'h0, "claim_after_reset");
    wr(4'h4, 32'hFF);
    rd_chk(4'h4, 32'h0, "pending_ro");
    wr(4'hC, 32'hFFFF);
    rd_chk(4'hC, 32'h0, "unmapped_rd");
    wr(4'h0, 32'hFFFF_FF81);
    rd_chk(4'h0, 32'h81, "enable_width");
    wr(4'h0, 32'h0);

    // single source: request, ack, claim readback
    bus.irq_i = 8'h01;
    wr(4'h0, 32'h01);
    wait_req(2, "req0_within2");
    check("req0_id", 32'(bus.int_id_o), 32'd0);
    bus.irq_i = '0;
    ack();
    rd_chk(4'h8, 32'h8000_0000, "claim0_active");
    cleanup();

    // priority, wrong-id complete ignored, then next source
    bus.irq_i = 8'h28;
    wr(4'h0, 32'hFF);
    wait_req(2, "req35_within2");
    check("prio_id3", 32'(bus.int_id_o), 32'd3);
    ack();
    wr(4'h8, 32'd5);
    rd_chk(4'h8, 32'h8000_0003, "wrong_complete");
    wr(4'h8, 32'd3);
    repeat (2) @(negedge clk);
    check("next_req", 32'(bus.int_req_o), 32'd1);
    check("next_id5", 32'(bus.int_id_o), 32'd5);
    ack();
    cleanup();

    // no preemption by a higher-priority source
    bus.irq_i = 8'h04;
    wr(4'h0, 32'hFF);
    wait_req(2, "req2_within2");
    bus.irq_i = 8'h05;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("nopreempt_id2", 32'(bus.int_id_o), 32'd2);
    end
    ack();
    check("req_drop_after_ack", 32'(bus.int_req_o), 32'd0);
    cleanup();

    // disable during request
    bus.irq_i = 8'h10;
    wr(4'h0, 32'hFF);
    wait_req(2, "req4_within2");
    check("req_id4", 32'(bus.int_id_o), 32'd4);
    wr(4'h0, 32'h00);
    check("disable_drop", 32'(bus.int_req_o), 32'd0);
    rd_chk(4'h4, 32'h0, "disable_pending");
    cleanup();

    // level source re-requests two cycles after complete
    bus.irq_i = 8'h02;
    wr(4'h0, 32'h02);
    wait_req(2, "req1_within2");
    ack();
    @(negedge clk);
    wr(4'h8, 32'd1);
    check("repend_c0", 32'(bus.int_req_o), 32'd0);
    @(negedge clk);
    check("repend_c1", 32'(bus.int_req_o), 32'd0);
    @(negedge clk);
    check("repend_c2", 32'(bus.int_req_o), 32'd1);
    check("repend_id1", 32'(bus.int_id_o), 32'd1);
    cleanup();

    // reset while active
    bus.irq_i = 8'h01;
    wr(4'h0, 32'h01);
    wait_req(2, "req0b_within2");
    ack();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_active_req", 32'(bus.int_req_o), 32'd0);
    check("rst_active_id", 32'(bus.int_id_o), 32'd0);
    check("rst_active_rd", bus.rd_data_o, 32'd0);
    bus.irq_i = '0;
    rd_chk(4'h8, 32'h0, "rst_claim_rd");
    rd_chk(4'h0, 32'h0, "rst_enable_rd");

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) bus.irq_i = N'($urandom());
      bus.int_ack_i = ($urandom_range(0, 3) == 0);
      bus.wr_en_i = ($urandom_range(0, 2) == 0);
      off = ($urandom_range(0, 4) == 4) ? 4'($urandom_range(0, 15)) : 4'(4 * $urandom_range(0, 2));
      bus.wr_addr_i = {28'($urandom()), off};
      if (off == 4'h8 && $urandom_range(0, 1) == 1)
        bus.wr_data_i = {27'($urandom()), 5'($urandom_range(0, N - 1))};
      else
        bus.wr_data_i = $urandom();
      bus.rd_addr_i = {28'($urandom()), 4'(4 * $urandom_range(0, 3))};
      @(negedge clk);
    end
    rst = 1'b0; bus.wr_en_i = 0; bus.int_ack_i = 0; bus.irq_i = '0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
